cnt3_sched: RTL

Scheduler that shares one synchronous up-counter between two requesters, each asking for a timed interval of 0..2^WIDTH-1 clock cycles. It arbitrates round-robin, loads and runs the shared counter for the winner, and returns a one-cycle `done` pulse to that requester. It sits between requesting control blocks and the counter datapath, replacing per-requester ripple counters with one clocked, glitch-free timer.

---
 rtl/cnt3_sched_pkg.sv | 22 ++
 rtl/cnt3_sched_cnt.sv | 34 +++
 rtl/cnt3_sched.sv | 105 ++++++++++
 3 files changed

// File: rtl/cnt3_sched_pkg.sv
// Shared definitions for the two-requester interval scheduler: state encoding,
// default widths and the round-robin pick used at grant time.
package cnt3_sched_pkg;

  localparam int DEF_WIDTH = 3;
  localparam int NREQ      = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Winner index: a lone requester always wins; on a tie the one not served last.
  function automatic logic rr_pick(input logic [NREQ-1:0] r, input logic last);
    if (r == 2'b11) begin
      return ~last;
    end
    return r[1];
  endfunction

endpackage

// File: rtl/cnt3_sched_cnt.sv
// Shared WIDTH-bit synchronous up-counter with synchronous clear and enable.
module cnt_sync #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (en) begin
      q_d = q_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/cnt3_sched.sv
// Round-robin scheduler sharing one clocked counter between two interval
// requesters; issues a one-cycle done pulse to the owner when its interval ends.
module cnt3_sched
  import cnt3_sched_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] len0,
  input  logic [WIDTH-1:0] len1,
  output logic [1:0]       gnt,
  output logic [1:0]       done,
  output logic             busy,
  output logic [WIDTH-1:0] Q
);

  state_t           state_q, state_d;
  logic [1:0]       gnt_q, gnt_d;
  logic             last_q, last_d;
  logic [WIDTH-1:0] tc_q, tc_d;

  logic             win;
  logic             owner;
  logic [WIDTH-1:0] len_w;
  logic             cnt_clr;
  logic             cnt_en;
  logic [WIDTH-1:0] cnt_q;

  cnt_sync #(
    .WIDTH (WIDTH)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .q     (cnt_q)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    tc_d    = tc_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    win     = rr_pick(req, last_q);
    len_w   = win ? len1 : len0;
    owner   = gnt_q[1];

    case (state_q)
      S_IDLE: begin
        if (|req) begin
          gnt_d   = win ? 2'b10 : 2'b01;
          tc_d    = len_w;
          cnt_clr = 1'b1;
          state_d = (len_w != '0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        // Abort takes precedence over completion on the same edge; Q freezes.
        if (!req[owner]) begin
          state_d = S_IDLE;
          gnt_d   = 2'b00;
          last_d  = owner;
        end else begin
          cnt_en = 1'b1;
          if (cnt_q == tc_q - WIDTH'(1)) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        gnt_d   = 2'b00;
        last_d  = owner;
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      gnt_q   <= 2'b00;
      last_q  <= 1'b1;
      tc_q    <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      tc_q    <= tc_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE) ? gnt_q : 2'b00;
  assign gnt  = gnt_q;
  assign Q    = cnt_q;

endmodule
